lvds_tx_serializer: RTL and testbench

- LVDS transmit side for board-to-board links: serializes parallel words onto a differential data pair and forwards a source-synchronous differential bit clock.
- The differential clock input path converts LVDS to single-ended. This block is the output direction: single-ended logic to LVDS pins via OBUFDS instances inside the block.
- Runs on the 4x clock from the clock generator (clk80M), with a valid/ready input handshake and a one-word holding register so frames can go back-to-back.

---
 rtl/lvds_tx_if.sv | 21 ++
 rtl/lvds_tx_serializer.sv | 124 ++++++++++++
 tb/tb_lvds_tx_serializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_tx_if.sv
// Valid/ready word handshake into the LVDS transmit serializer.
// The source drives data and valid; the serializer returns ready.
interface lvds_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/lvds_tx_serializer.sv
// LVDS transmit serializer: MSB-first data pair, forwarded bit clock,
// frame marker and a one-word holding register for back-to-back words.
module lvds_tx_serializer #(
  parameter int DATA_W  = 16,
  parameter int BIT_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  lvds_tx_if.slave    tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [15:0] tx_count,
  output logic        sd_p,
  output logic        sd_n,
  output logic        fclk_p,
  output logic        fclk_n,
  output logic        frm_o
);
  localparam int PH_W = $clog2(BIT_DIV);
  localparam int IX_W = $clog2(DATA_W);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(BIT_DIV / 2);
  localparam logic [IX_W-1:0] IX_LAST = IX_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [PH_W-1:0]   ph;
  logic [PH_W-1:0]   ph_nxt;
  logic [IX_W-1:0]   idx;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] sh;
  logic              hold_full;
  logic              ready_q;
  logic              sd_q;
  logic              fclk_q;
  logic              frm_q;
  logic              bnd;
  logic              last;
  logic              load;
  logic              accept;
  logic              hold_nxt;

  assign bnd      = ph == PH_LAST;
  assign ph_nxt   = bnd ? '0 : ph + 1'b1;
  assign last     = state == SHIFT && idx == IX_LAST;
  assign load     = bnd && hold_full && (state == IDLE || last);
  assign accept   = tx.tx_valid && ready_q;
  assign hold_nxt = accept || (hold_full && !load);

  assign tx.tx_ready = ready_q;
  assign tx_busy     = state == SHIFT || hold_full;
  assign frm_o       = frm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ph        <= '0;
      idx       <= '0;
      hold      <= '0;
      sh        <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b0;
      sd_q      <= 1'b0;
      fclk_q    <= 1'b0;
      frm_q     <= 1'b0;
      tx_done   <= 1'b0;
      tx_count  <= '0;
    end else begin
      ph        <= ph_nxt;
      // fclk tracks the phase it will have next, so it rises mid-bit
      fclk_q    <= ph_nxt >= PH_HALF;
      hold_full <= hold_nxt;
      ready_q   <= !hold_nxt;
      tx_done   <= 1'b0;
      if (accept)
        hold <= tx.tx_data;
      if (bnd) begin
        unique case (1'b1)
          load: begin
            state <= SHIFT;
            sd_q  <= hold[DATA_W-1];
            sh    <= hold << 1;
            idx   <= '0;
            frm_q <= 1'b1;
          end
          (state == SHIFT && !last): begin
            sd_q <= sh[DATA_W-1];
            sh   <= sh << 1;
            idx  <= idx + 1'b1;
          end
          default: begin
            state <= IDLE;
            sd_q  <= 1'b0;
            frm_q <= 1'b0;
          end
        endcase
        if (last) begin
          tx_done  <= 1'b1;
          tx_count <= tx_count + 1'b1;
        end
      end
    end
  end

  // Vendor builds map the pads onto OBUFDS; otherwise model the pair.
`ifdef LVDS_TX_VENDOR_PRIMS
  OBUFDS u_sd_buf (
    .I  (sd_q),
    .O  (sd_p),
    .OB (sd_n)
  );
  OBUFDS u_fclk_buf (
    .I  (fclk_q),
    .O  (fclk_p),
    .OB (fclk_n)
  );
`else
  assign sd_p   = sd_q;
  assign sd_n   = ~sd_q;
  assign fclk_p = fclk_q;
  assign fclk_n = ~fclk_q;
`endif
endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Randomized scoreboard bench for lvds_tx_serializer: words are queued
// on accept and rebuilt from the pins at each forwarded-clock rise.
`timescale 1ns/1ps
module tb_lvds_tx_serializer;
  localparam int DW       = 16;
  localparam int BD       = 4;
  localparam int WORD_CYC = DW * BD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_busy;
  logic        tx_done;
  logic [15:0] tx_count;
  logic        sd_p;
  logic        sd_n;
  logic        fclk_p;
  logic        fclk_n;
  logic        frm_o;

  lvds_tx_if #(.DATA_W(DW)) ifc ();

  lvds_tx_serializer #(
    .DATA_W  (DW),
    .BIT_DIV (BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx       (ifc),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_count (tx_count),
    .sd_p     (sd_p),
    .sd_n     (sd_n),
    .fclk_p   (fclk_p),
    .fclk_n   (fclk_n),
    .frm_o    (frm_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  int cnt_off = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  // Cycles since reset release; the bit phase is cyc mod BD.
  int cyc  = 0;
  int tick = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  always @(posedge clk) tick <= tick + 1;

  logic          prev_sd, prev_frm, prev_fclk;
  logic [DW-1:0] acc;
  int nbits, words_rx, dones, run_len, run_words, done_t0, done_t1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sd = 0; prev_frm = 0; prev_fclk = 0;
      acc = '0; nbits = 0; words_rx = 0; dones = 0;
      run_len = 0; run_words = 0;
    end else begin
      chk("sd_n_compl", sd_n, !sd_p);
      chk("fclk_n_compl", fclk_n, !fclk_p);
      chk("fclk_phase", fclk_p, (cyc % BD) >= BD / 2);
      if (cyc % BD != 0) begin
        chk("sd_stable", sd_p, prev_sd);
        chk("frm_stable", frm_o, prev_frm);
      end
      if (!frm_o) chk("sd_idle", sd_p, 0);
      if (fclk_p && !prev_fclk && frm_o) begin
        acc = {acc[DW-2:0], sd_p};
        nbits++;
        if (nbits == DW) begin
          nbits = 0;
          words_rx++;
          run_words++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL word_unexpected: got %h, expected no word", acc);
          end else begin
            chk("word", acc, exp_q.pop_front());
          end
        end
      end
      if (frm_o) run_len++;
      else if (prev_frm) begin
        chk("frm_len", run_len, run_words * WORD_CYC);
        run_len = 0;
        run_words = 0;
      end
      if (tx_done) begin
        dones++;
        done_t0 = done_t1;
        done_t1 = tick;
        chk("done_vs_words", dones, words_rx);
        chk("count", tx_count, 16'(words_rx + cnt_off));
      end
      prev_sd = sd_p; prev_frm = frm_o; prev_fclk = fclk_p;
    end
  end

  task automatic send(input logic [DW-1:0] w);
    int g = 0;
    @(negedge clk);
    ifc.tx_data  = w;
    ifc.tx_valid = 1'b1;
    while (!ifc.tx_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (!ifc.tx_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: ready 0 for word %h, expected 1", w);
      ifc.tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(w);
    #1;
    ifc.tx_valid = 1'b0;
    chk("ready_after_accept", ifc.tx_ready, 0);
    chk("busy_after_accept", tx_busy, 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((tx_busy || frm_o) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (tx_busy || frm_o) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: busy=%0b frm=%0b, expected 0", tx_busy, frm_o);
    end
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit hit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_sd", sd_p, 0);
    chk("rst_fclk", fclk_p, 0);
    chk("rst_frm", frm_o, 0);
    chk("rst_ready", ifc.tx_ready, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_count", tx_count, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_cycle1", ifc.tx_ready, 1);
    repeat (40) @(negedge clk);

    send(16'hA5C3);
    wait_idle();
    chk("count_single", tx_count, 1);

    send(16'hFFFF);
    send(16'h0001);
    wait_idle();
    chk("count_b2b", tx_count, 3);
    chk("done_gap", done_t1 - done_t0, WORD_CYC);

    send(16'h1357);
    send(16'h8000);
    send(16'h7FFE);
    wait_idle();
    chk("count_bp", tx_count, 6);

    repeat (20) begin
      send(16'($urandom));
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end
    wait_idle();
    chk("count_rand", tx_count, 26);

    send(16'h1234);
    g = 0;
    while (!frm_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (7 * BD + 2) @(negedge clk);
    chk("pre_rst_frm", frm_o, 1);
    chk("pre_rst_fclk", fclk_p, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    cnt_off = 0;
    #1;
    chk("abort_sd", sd_p, 0);
    chk("abort_fclk", fclk_p, 0);
    chk("abort_frm", frm_o, 0);
    chk("abort_busy", tx_busy, 0);
    chk("abort_done", tx_done, 0);
    chk("abort_count", tx_count, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    send(16'h1234);
    wait_idle();
    chk("count_after_abort", tx_count, 1);

    @(negedge clk);
    force dut.tx_count = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.tx_count;
    cnt_off = 16'hFFFF - words_rx;
    @(negedge clk);
    chk("count_forced", tx_count, 16'hFFFF);
    send(16'($urandom));
    wait_idle();
    chk("count_wrap", tx_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
